// File: rtl/axi_b_arbiter.sv
// Round-robin merge of NUM_IN AXI B channels onto one registered master B channel.
// The output stage is a single skid-free register; ready back to the slaves is data-independent.
module axi_b_arbiter #(
  parameter  int NUM_IN     = 4,
  parameter  int ID_WIDTH   = 4,
  parameter  int USER_WIDTH = 6,
  localparam int SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_IN-1:0]            slave_valid_i,
  input  logic [2*NUM_IN-1:0]          slave_resp_i,
  input  logic [ID_WIDTH*NUM_IN-1:0]   slave_id_i,
  input  logic [USER_WIDTH*NUM_IN-1:0] slave_user_i,
  output logic [NUM_IN-1:0]            slave_ready_o,
  output logic                         master_valid_o,
  output logic [1:0]                   master_resp_o,
  output logic [ID_WIDTH-1:0]          master_id_o,
  output logic [USER_WIDTH-1:0]        master_user_o,
  output logic [SRC_W-1:0]             master_src_o,
  input  logic                         master_ready_i
);

  logic                  valid_q;
  logic [1:0]            resp_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [SRC_W-1:0]      src_q;
  logic [SRC_W-1:0]      ptr_q;

  logic                  load_en;
  logic                  found;
  logic [SRC_W-1:0]      winner;
  logic [SRC_W:0]        cand;

  logic [1:0]            resp_arr [NUM_IN];
  logic [ID_WIDTH-1:0]   id_arr   [NUM_IN];
  logic [USER_WIDTH-1:0] user_arr [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign resp_arr[k] = slave_resp_i[2*k +: 2];
    assign id_arr[k]   = slave_id_i[ID_WIDTH*k +: ID_WIDTH];
    assign user_arr[k] = slave_user_i[USER_WIDTH*k +: USER_WIDTH];
  end

  assign load_en = !valid_q || master_ready_i;

  // Scan from ptr upwards, wrapping at NUM_IN; the first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = {1'b0, ptr_q} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(NUM_IN)) begin
        cand = cand - (SRC_W+1)'(NUM_IN);
      end
      if (!found && slave_valid_i[cand[SRC_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[SRC_W-1:0];
      end
    end
  end

  // Gated by rst_ni so no slave sees a handshake while the block is held in reset.
  assign slave_ready_o = (rst_ni && load_en && found) ? (NUM_IN'(1) << winner) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      resp_q  <= '0;
      id_q    <= '0;
      user_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else if (load_en) begin
      if (found) begin
        valid_q <= 1'b1;
        resp_q  <= resp_arr[winner];
        id_q    <= id_arr[winner];
        user_q  <= user_arr[winner];
        src_q   <= winner;
        ptr_q   <= (winner == SRC_W'(NUM_IN-1)) ? '0 : winner + SRC_W'(1);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign master_valid_o = valid_q;
  assign master_resp_o  = resp_q;
  assign master_id_o    = id_q;
  assign master_user_o  = user_q;
  assign master_src_o   = src_q;

endmodule

// File: tb/tb_axi_b_arbiter.sv
// Randomised and directed bench for axi_b_arbiter, checked against a queue-based
// round-robin reference model and a per-input scoreboard.
module tb_axi_b_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
    logic [5:0] user;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   s_valid;
  logic [2*N-1:0] s_resp;
  logic [4*N-1:0] s_id;
  logic [6*N-1:0] s_user;
  logic [N-1:0]   s_ready;
  logic           m_valid;
  logic [1:0]     m_resp;
  logic [3:0]     m_id;
  logic [5:0]     m_user;
  logic [1:0]     m_src;
  logic           m_ready;

  int compare_count = 0;
  int fail_count    = 0;

  logic       mdl_valid;
  logic [1:0] mdl_resp;
  logic [3:0] mdl_id;
  logic [5:0] mdl_user;
  int         mdl_src;
  int         mdl_ptr;
  beat_t      sb [N][$];
  int         wait_cnt [N];
  logic [N-1:0] last_grant;

  logic [N-1:0] pend;
  beat_t        pend_beat [N];
  logic [14:0]  snapshot;

  axi_b_arbiter #(.NUM_IN(N), .ID_WIDTH(4), .USER_WIDTH(6)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slave_valid_i  (s_valid),
    .slave_resp_i   (s_resp),
    .slave_id_i     (s_id),
    .slave_user_i   (s_user),
    .slave_ready_o  (s_ready),
    .master_valid_o (m_valid),
    .master_resp_o  (m_resp),
    .master_id_o    (m_id),
    .master_user_o  (m_user),
    .master_src_o   (m_src),
    .master_ready_i (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setBeat(input int k, input logic [1:0] r, input logic [3:0] i, input logic [5:0] u);
    s_resp[2*k +: 2] = r;
    s_id[4*k +: 4]   = i;
    s_user[6*k +: 6] = u;
  endtask

  task automatic randomData();
    for (int k = 0; k < N; k++) begin
      setBeat(k, 2'($urandom), 4'($urandom), 6'($urandom));
    end
  endtask

  // One clock: drive at negedge, check ready against the model, advance the model, check the register.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] vld, input logic mrdy);
    int         win;
    logic       load_en;
    logic [N-1:0] exp_ready;
    beat_t      b;
    @(negedge clk);
    rst_n   = rst;
    s_valid = vld;
    m_ready = mrdy;
    #1;
    load_en   = !mdl_valid || mrdy;
    win       = -1;
    exp_ready = '0;
    if (rst && load_en) begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && vld[(mdl_ptr + i) % N]) win = (mdl_ptr + i) % N;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    last_grant = exp_ready;
    checkOutput("slave_ready", 32'(s_ready), 32'(exp_ready));

    if (!rst) begin
      mdl_valid = 1'b0;
      mdl_resp  = '0;
      mdl_id    = '0;
      mdl_user  = '0;
      mdl_src   = 0;
      mdl_ptr   = 0;
      for (int k = 0; k < N; k++) begin
        sb[k].delete();
        wait_cnt[k] = 0;
      end
    end else begin
      if (mdl_valid && mrdy && sb[mdl_src].size() > 0) begin
        b = sb[mdl_src].pop_front();
        checkOutput("sb_resp", 32'(m_resp), 32'(b.resp));
        checkOutput("sb_id",   32'(m_id),   32'(b.id));
        checkOutput("sb_user", 32'(m_user), 32'(b.user));
      end
      if (load_en) begin
        for (int k = 0; k < N; k++) begin
          if (k != win) wait_cnt[k] = vld[k] ? wait_cnt[k] + 1 : 0;
        end
        if (win >= 0) begin
          checkOutput("starve_bound", 32'(wait_cnt[win] < N), 32'd1);
          wait_cnt[win] = 0;
          b.resp = s_resp[2*win +: 2];
          b.id   = s_id[4*win +: 4];
          b.user = s_user[6*win +: 6];
          sb[win].push_back(b);
          mdl_valid = 1'b1;
          mdl_resp  = b.resp;
          mdl_id    = b.id;
          mdl_user  = b.user;
          mdl_src   = win;
          mdl_ptr   = (win + 1) % N;
        end else begin
          mdl_valid = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    checkOutput("master_valid", 32'(m_valid), 32'(mdl_valid));
    checkOutput("master_resp",  32'(m_resp),  32'(mdl_resp));
    checkOutput("master_id",    32'(m_id),    32'(mdl_id));
    checkOutput("master_user",  32'(m_user),  32'(mdl_user));
    checkOutput("master_src",   32'(m_src),   32'(mdl_src));
  endtask

  initial begin
    rst_n     = 1'b0;
    s_valid   = '0;
    s_resp    = '0;
    s_id      = '0;
    s_user    = '0;
    m_ready   = 1'b0;
    mdl_valid = 1'b0;
    mdl_resp  = '0;
    mdl_id    = '0;
    mdl_user  = '0;
    mdl_src   = 0;
    mdl_ptr   = 0;
    pend      = '0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;

    // Reset with random activity on the inputs: ready must stay low, outputs zero.
    for (int n = 0; n < 3; n++) begin
      randomData();
      applyStimulus(1'b0, 4'($urandom), 1'($urandom));
    end

    // Lone requester on input 2.
    randomData();
    setBeat(2, 2'b10, 4'h5, 6'h2a);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("single_resp", 32'(m_resp), 32'h2);
    checkOutput("single_id",   32'(m_id),   32'h5);
    checkOutput("single_src",  32'(m_src),  32'd2);

    // Every input requesting after reset: strict rotation, one beat per cycle.
    applyStimulus(1'b0, '0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      randomData();
      applyStimulus(1'b1, '1, 1'b1);
      checkOutput("rr_order", 32'(m_src), 32'(n % N));
    end

    // Backpressure: held beat must not move and nobody may be granted.
    snapshot = {m_valid, m_resp, m_id, m_user, m_src};
    for (int n = 0; n < 5; n++) begin
      randomData();
      applyStimulus(1'b1, '1, 1'b0);
      checkOutput("bp_ready", 32'(s_ready), 32'd0);
      checkOutput("bp_hold", 32'({m_valid, m_resp, m_id, m_user, m_src}), 32'(snapshot));
    end
    randomData();
    applyStimulus(1'b1, '1, 1'b1);
    checkOutput("bp_release_src", 32'(m_src), 32'd1);

    // Reset while a beat is held, then inputs 1 and 2 compete from ptr = 0.
    applyStimulus(1'b0, '1, 1'b0);
    checkOutput("rst_mid_valid", 32'(m_valid), 32'd0);
    randomData();
    applyStimulus(1'b1, 4'b0110, 1'b1);
    checkOutput("rst_first_src", 32'(m_src), 32'd1);

    // Pointer wrap: drive ptr to 3, then inputs 1 and 3 compete.
    applyStimulus(1'b0, '0, 1'b1);
    randomData();
    applyStimulus(1'b1, 4'b0100, 1'b1);
    randomData();
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("wrap_src3", 32'(m_src), 32'd3);
    randomData();
    applyStimulus(1'b1, 4'b0010, 1'b1);
    checkOutput("wrap_src1", 32'(m_src), 32'd1);

    // Random traffic: each input holds its beat until granted, ready toggles randomly.
    pend = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          pend_beat[k] = beat_t'($urandom);
        end
        if (pend[k]) setBeat(k, pend_beat[k].resp, pend_beat[k].id, pend_beat[k].user);
        else         setBeat(k, 2'($urandom), 4'($urandom), 6'($urandom));
      end
      applyStimulus(1'b1, pend, 1'($urandom_range(0, 3) != 0));
      pend = pend & ~last_grant;
    end

    // Drain whatever is still held so the scoreboard sees every beat delivered.
    for (int n = 0; n < 2; n++) applyStimulus(1'b1, '0, 1'b1);
    for (int k = 0; k < N; k++) begin
      checkOutput("sb_drained", 32'(sb[k].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/axi_b_arbiter.md
AXI_B_ARBITER -- requirements
Module: axi_b_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4: number of slave-side B channels merged onto one master B channel; legal range 2..16.
REQ-002 Parameter ID_WIDTH, default 4: B-channel ID width.
REQ-003 Parameter USER_WIDTH, default 6: B-channel user width.
REQ-004 Derived width SRC_W = max(1, clog2(NUM_IN)).
REQ-005 Port list:
- clk_i  in  1  single clock; all logic samples on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- slave_valid_i  in  NUM_IN  per-input B valid.
- slave_resp_i  in  2*NUM_IN  per-input resp; input k occupies bits [2k+1:2k].
- slave_id_i  in  ID_WIDTH*NUM_IN  per-input ID; same packing.
- slave_user_i  in  USER_WIDTH*NUM_IN  per-input user; same packing.
- slave_ready_o  out  NUM_IN  per-input ready.
- master_valid_o  out  1  merged B valid.
- master_resp_o  out  2  merged resp.
- master_id_o  out  ID_WIDTH  merged ID.
- master_user_o  out  USER_WIDTH  merged user.
- master_src_o  out  SRC_W  index of the input that supplied the current beat.
- master_ready_i  in  1  downstream ready.

Function
REQ-006 The block SHALL hold a one-entry output register {valid, resp, id, user, src} that drives the master_* outputs directly; no combinational path from slave_* to master_*.
REQ-007 load_en SHALL be (!master_valid_o || master_ready_i).
REQ-008 When load_en is 1 and any slave_valid_i bit is set, the block SHALL select exactly one winner by round-robin: the first set bit at index ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
REQ-009 slave_ready_o[winner] SHALL be 1 only in a cycle where load_en is 1 and a winner exists; all other slave_ready_o bits SHALL be 0.
REQ-010 slave_ready_o SHALL depend combinationally only on slave_valid_i, ptr, master_valid_o and master_ready_i; it SHALL NOT depend on slave data.
REQ-011 On a winner handshake, the register SHALL capture the winner's resp/id/user, src = winner index, and valid = 1; ptr SHALL become (winner+1) mod NUM_IN.
REQ-012 When load_en is 1 and no slave_valid_i bit is set, valid SHALL clear to 0; data, src and ptr SHALL hold their values.
REQ-013 When load_en is 0 (master_valid_o=1, master_ready_i=0), the register and ptr SHALL hold; master_* outputs SHALL be stable until the handshake.
REQ-014 Latency: a beat accepted from a slave in cycle N SHALL appear on master_valid_o in cycle N+1.
REQ-015 Simultaneous master handshake and slave handshake in the same cycle SHALL complete both; sustained throughput is one beat per cycle.
REQ-016 ptr wrap-around: a winner at index NUM_IN-1 SHALL set ptr to 0.
REQ-017 A slave input whose valid is held with no grant SHALL be granted within NUM_IN load_en cycles; no input can starve.
REQ-018 Beats SHALL be neither dropped nor duplicated; each slave handshake yields exactly one master handshake carrying identical resp/id/user.

Reset
REQ-019 While rst_ni is 0 at a rising clk_i edge: master_valid_o = 0, master_resp_o = 0, master_id_o = 0, master_user_o = 0, master_src_o = 0, ptr = 0.
REQ-020 While rst_ni is 0, slave_ready_o SHALL be all zeros.
REQ-021 Reset asserted mid-transfer SHALL discard any held beat; after release, the first grant SHALL follow the rules above with ptr = 0.

Verification
REQ-022 Single input: NUM_IN=4, only input 2 valid with resp=2'b10, id=4'h5, master_ready_i=1 -> slave_ready_o=4'b0100; next cycle master_valid_o=1, resp=2'b10, id=4'h5, src=2.
REQ-023 All inputs valid continuously, master_ready_i=1, after reset -> grant order 0,1,2,3,0; master_src_o matches this order, one beat per cycle.
REQ-024 Backpressure: beat held, master_ready_i=0 for 5 cycles -> slave_ready_o=0 and master_* stable for all 5 cycles; master_ready_i=1 -> next queued beat loads in the same cycle.
REQ-025 Wrap: ptr=3, inputs 1 and 3 valid -> input 3 granted, ptr=0; next grant is input 1.
REQ-026 Reset mid-operation: rst_ni=0 for one cycle while master_valid_o=1 -> master_valid_o=0 next cycle, ptr=0; with inputs 1 and 2 then valid, input 1 is granted first.
REQ-027 Random stimulus with random master_ready_i, scoreboard per input -> no loss, duplication or reordering within any single input; every held valid is granted within 4 load cycles.
